// File: rtl/cla_pkg.sv
// Shared constants and the flat second-level lookahead carry equations for the 16-bit CLA.
package cla_pkg;
    localparam int CLA_WIDTH   = 16;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = 4;

    // Returns {c4, c3, c2, c1}. Each carry is a flat sum-of-products of (p, g, cin).
    function automatic logic [3:0] cla_carries(input logic [3:0] p, input logic [3:0] g,
                                               input logic cin);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction
endpackage

// File: rtl/cla_16bit_lookahead_unit_if.sv
// Operand/result bundle for the 16-bit CLA; master drives operands, slave returns results.
interface cla_16bit_lookahead_unit_if;
    import cla_pkg::*;
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
    logic                 c_in;
    logic [CLA_WIDTH-1:0] sum;
    logic                 carry;
    logic                 p_out;
    logic                 g_out;

    modport master (output a, b, c_in, input sum, carry, p_out, g_out);
    modport slave  (input a, b, c_in, output sum, carry, p_out, g_out);
endinterface

// File: rtl/cla_4bit_group.sv
// Combinational 4-bit lookahead group: sum bits plus group propagate/generate.
module cla_4bit_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);
    logic [3:0] p, g;
    logic       c1, c2, c3;

    assign p  = a ^ b;
    assign g  = a & b;
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign s  = p ^ {c3, c2, c1, cin};
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/cla_16bit_lookahead_unit.sv
// 16-bit two-level carry-lookahead adder with a single output register stage.
module cla_16bit_lookahead_unit
    import cla_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    cla_16bit_lookahead_unit_if.slave     bus
);
    logic [CLA_NGROUPS-1:0][CLA_GROUP-1:0] a_g, b_g, s_g;
    logic [CLA_NGROUPS-1:0]                gp, gg;
    logic [CLA_NGROUPS:0]                  gc;

    logic [CLA_WIDTH-1:0] sum_d, sum_q;
    logic                 carry_d, carry_q, p_d, p_q, g_d, g_q;

    assign a_g = bus.a;
    assign b_g = bus.b;

    genvar j;
    generate
        for (j = 0; j < CLA_NGROUPS; j++) begin : g_grp
            cla_4bit_group u_grp (
                .a   (a_g[j]),
                .b   (b_g[j]),
                .cin (gc[j]),
                .s   (s_g[j]),
                .pg  (gp[j]),
                .gg  (gg[j])
            );
        end
    endgenerate

    // Group carries all come straight from c_in and the group P/G, never from each other.
    assign gc[0]             = bus.c_in;
    assign gc[CLA_NGROUPS:1] = cla_carries(gp, gg, bus.c_in);

    always_comb begin
        sum_d   = s_g;
        carry_d = gc[CLA_NGROUPS];
        p_d     = &gp;
        g_d     = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            p_q     <= p_d;
            g_q     <= g_d;
        end
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
    assign bus.p_out = p_q;
    assign bus.g_out = g_q;
endmodule

// File: tb/tb_cla_16bit_lookahead_unit.sv
// Directed and random checks of the registered 16-bit CLA against hand values and a+b+c_in.
module tb_cla_16bit_lookahead_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] prev_sum = '0;
    logic        prev_carry = 1'b0;

    cla_16bit_lookahead_unit_if bus ();

    cla_16bit_lookahead_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sum"},   {1'b0, bus.sum}, 17'h0);
        chk({tag, ".carry"}, {16'h0, bus.carry}, 17'h0);
        chk({tag, ".p_out"}, {16'h0, bus.p_out}, 17'h0);
        chk({tag, ".g_out"}, {16'h0, bus.g_out}, 17'h0);
    endtask

    // Drive at negedge (old result must still hold), then check the new result after the edge.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] es, input logic ec);
        @(negedge clk);
        chk({tag, ".hold"}, {bus.carry, bus.sum}, {prev_carry, prev_sum});
        bus.a = a; bus.b = b; bus.c_in = ci;
        @(posedge clk); #1;
        chk({tag, ".sum"},   {1'b0, bus.sum}, {1'b0, es});
        chk({tag, ".carry"}, {16'h0, bus.carry}, {16'h0, ec});
        prev_sum = es; prev_carry = ec;
    endtask

    task automatic chk_pg(input string tag, input logic ep, input logic eg);
        chk({tag, ".p_out"}, {16'h0, bus.p_out}, {16'h0, ep});
        chk({tag, ".g_out"}, {16'h0, bus.g_out}, {16'h0, eg});
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] full, gen;

        bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        #1 rst = 1'b1;
        #2 chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        step("add5_9", 16'd5, 16'd9, 1'b0, 16'd14, 1'b0);
        step("b2b0", 16'd111, 16'd41, 1'b0, 16'd152, 1'b0);
        step("b2b1", 16'd15, 16'd9, 1'b0, 16'd24, 1'b0);
        step("b2b2", 16'd2, 16'd3, 1'b0, 16'd5, 1'b0);
        step("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk_pg("zero", 1'b0, 1'b0);
        step("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        chk_pg("ffff_1", 1'b0, 1'b1);
        step("00ff_1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        step("ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        chk_pg("ffff_cin", 1'b1, 1'b0);
        step("ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        chk_pg("ffff_ffff", 1'b0, 1'b1);
        step("grp_ripple", 16'h0FF0, 16'h0010, 1'b0, 16'h1000, 1'b0);
        step("grp_pg", 16'h8421, 16'h7BDE, 1'b1, 16'h0000, 1'b1);
        chk_pg("grp_pg", 1'b1, 1'b0);

        // Mid-operation reset: outputs clear at once and stay clear while rst is high.
        step("pre_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        @(posedge clk); #1 chk_zero("rst_held");
        @(negedge clk) rst = 1'b0;
        prev_sum = '0; prev_carry = 1'b0;
        chk_zero("rst_release");
        @(posedge clk); #1;
        chk("post_rst.sum", {1'b0, bus.sum}, {1'b0, 16'h5555});
        prev_sum = 16'h5555;

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            gen  = {1'b0, ra} + {1'b0, rb};
            step("rand", ra, rb, rc, full[15:0], full[16]);
            chk_pg("rand", &(ra ^ rb), gen[16]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
